// File: rtl/rep3_serial_tx.sv
// rep3_serial_tx: LSB-first framed serial transmitter with every symbol repeated REP cycles.
// Frame: START(1), data bits, even parity, STOP(0); outputs are registered from next-state values.
module rep3_serial_tx #(
    parameter int DATA_W = 8,
    parameter int REP    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              tx_frame,
    output logic              tx_done
);
    localparam int RW = (REP > 2) ? $clog2(REP) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    if (REP < 3 || REP % 2 == 0) begin : g_bad_rep
        $error("rep3_serial_tx: REP must be odd and >= 3");
    end
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
        $error("rep3_serial_tx: DATA_W must be 1..32");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_d;
    logic [RW-1:0]     rep_cnt, rep_d;
    logic [BW-1:0]     bit_cnt, bit_d;
    logic [DATA_W-1:0] shift, shift_d;
    logic              par, par_d, tx_d, frame_d, done_d, last_rep;

    assign in_ready = state == IDLE;
    assign last_rep = rep_cnt == REP_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rep_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            tx_out   <= 1'b0;
            tx_frame <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_d;
            rep_cnt  <= rep_d;
            bit_cnt  <= bit_d;
            shift    <= shift_d;
            par      <= par_d;
            tx_out   <= tx_d;
            tx_frame <= frame_d;
            tx_done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        rep_d   = last_rep ? '0 : rep_cnt + 1'b1;
        bit_d   = bit_cnt;
        shift_d = shift;
        par_d   = par;
        case (state)
            IDLE: begin
                rep_d = '0;
                if (in_valid) begin
                    state_d = START;
                    shift_d = in_data;
                    par_d   = ^in_data;
                end
            end
            START: if (last_rep) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (last_rep) begin
                shift_d = shift >> 1;
                bit_d   = bit_cnt + 1'b1;
                if (bit_cnt == BIT_LAST) begin
                    state_d = PARITY;
                    bit_d   = '0;
                end
            end
            PARITY: if (last_rep) state_d = STOP;
            STOP:   if (last_rep) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered line lines up with it.
    always_comb begin
        tx_d    = (state_d == START) | ((state_d == DATA) & shift_d[0]) | ((state_d == PARITY) & par_d);
        frame_d = state_d != IDLE;
        done_d  = (state_d == STOP) && (rep_d == REP_LAST);
    end
endmodule

// File: tb/tb_rep3_serial_tx.sv
// tb_rep3_serial_tx: directed checks of framing, timing, reset abort and a small-parameter instance.
module tb_rep3_serial_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, tx_out, tx_frame, tx_done;
    logic [0:0] b_data = 1'b0;
    logic       b_valid = 1'b0;
    logic       b_ready, b_out, b_frame, b_done;
    int         errs = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    rep3_serial_tx dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx_out(tx_out), .tx_frame(tx_frame), .tx_done(tx_done)
    );

    rep3_serial_tx #(.DATA_W(1), .REP(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .tx_out(b_out), .tx_frame(b_frame), .tx_done(b_done)
    );

    // sym is the 11 frame symbols in time order, first symbol in the MSB.
    function automatic logic [32:0] expand(input logic [10:0] sym);
        logic [32:0] r;
        for (int i = 0; i < 33; i++) r[i] = sym[10 - i / 3];
        return r;
    endfunction

    function automatic logic [7:0] vote(input logic [32:0] line);
        logic [7:0] r;
        for (int k = 0; k < 8; k++)
            r[k] = (line[3*k+3] & line[3*k+4]) | (line[3*k+3] & line[3*k+5]) | (line[3*k+4] & line[3*k+5]);
        return r;
    endfunction

    task automatic run_frame(input logic [7:0] d, output logic hs_ok, output logic [32:0] line,
                             output logic [32:0] done, output logic [32:0] frm, output logic [32:0] rdy);
        @(negedge clk);
        hs_ok = in_ready;
        in_data = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data = ~d;
        for (int i = 0; i < 33; i++) begin
            line[i] = tx_out;
            done[i] = tx_done;
            frm[i]  = tx_frame;
            rdy[i]  = in_ready;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        b_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({tx_out, tx_frame, in_ready, tx_done} !== 4'b0010) begin
                errs++;
                $display("FAIL reset_hold: out/frame/ready/done=%b want 0010", {tx_out, tx_frame, in_ready, tx_done});
            end
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if ({tx_out, tx_frame, in_ready, tx_done} !== 4'b0010) begin
                errs++;
                $display("FAIL idle: out/frame/ready/done=%b want 0010", {tx_out, tx_frame, in_ready, tx_done});
            end
        end
        checks++;
        if ({b_out, b_frame, b_ready, b_done} !== 4'b0010) begin
            errs++;
            $display("FAIL idle_b: out/frame/ready/done=%b want 0010", {b_out, b_frame, b_ready, b_done});
        end
    endtask

    task automatic test_frame(input string name, input logic [7:0] d, input logic [10:0] sym);
        logic hs_ok;
        logic [32:0] line, done, frm, rdy;
        run_frame(d, hs_ok, line, done, frm, rdy);
        checks++;
        if (hs_ok !== 1'b1) begin errs++; $display("FAIL %s_ready_before: got %b want 1", name, hs_ok); end
        checks++;
        if (line !== expand(sym)) begin errs++; $display("FAIL %s_line: got %b want %b", name, line, expand(sym)); end
        checks++;
        if (done !== 33'h1_0000_0000) begin errs++; $display("FAIL %s_done: got %b want %b", name, done, 33'h1_0000_0000); end
        checks++;
        if (frm !== '1) begin errs++; $display("FAIL %s_frame: got %b want all ones", name, frm); end
        checks++;
        if (rdy !== '0) begin errs++; $display("FAIL %s_ready_busy: got %b want all zeros", name, rdy); end
        checks++;
        if (vote(line) !== d) begin errs++; $display("FAIL %s_vote: got %h want %h", name, vote(line), d); end
        checks++;
        if ({tx_out, tx_frame, in_ready, tx_done} !== 4'b0010) begin
            errs++;
            $display("FAIL %s_idle_after: out/frame/ready/done=%b want 0010", name, {tx_out, tx_frame, in_ready, tx_done});
        end
    endtask

    task automatic test_back_to_back();
        logic [66:0] line, rdy, frm, done, exp_line, exp_rdy;
        exp_line = {expand(11'b11100001100), 1'b0, expand(11'b10011110000)};
        exp_rdy  = 67'h1 << 33;
        @(negedge clk);
        in_data = 8'h3C;
        in_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 67; i++) begin
            if (i == 0)  in_data = 8'hC3;
            if (i == 10) in_data = 8'h00;
            if (i == 20) in_data = 8'hC3;
            if (i == 34) in_valid = 1'b0;
            line[i] = tx_out;
            rdy[i]  = in_ready;
            frm[i]  = tx_frame;
            done[i] = tx_done;
            @(negedge clk);
        end
        checks++;
        if (line !== exp_line) begin errs++; $display("FAIL b2b_line: got %b want %b", line, exp_line); end
        checks++;
        if (rdy !== exp_rdy) begin errs++; $display("FAIL b2b_ready: got %b want %b", rdy, exp_rdy); end
        checks++;
        if (frm !== ~exp_rdy) begin errs++; $display("FAIL b2b_frame: got %b want %b", frm, ~exp_rdy); end
        checks++;
        if (done !== ((67'h1 << 32) | (67'h1 << 66))) begin errs++; $display("FAIL b2b_done: got %b", done); end
        checks++;
        if ({line[33], line[34]} !== 2'b01) begin
            errs++;
            $display("FAIL b2b_second_start: cycles 34/35 tx_out=%b want 01", {line[33], line[34]});
        end
        checks++;
        if ({tx_frame, in_ready} !== 2'b01) begin
            errs++;
            $display("FAIL b2b_idle_after: frame/ready=%b want 01", {tx_frame, in_ready});
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        in_data = 8'hA5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
        checks++;
        if (tx_frame !== 1'b1) begin errs++; $display("FAIL mid_busy: tx_frame=%b want 1", tx_frame); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_out, tx_frame, in_ready, tx_done} !== 4'b0010) begin
            errs++;
            $display("FAIL mid_async_abort: out/frame/ready/done=%b want 0010", {tx_out, tx_frame, in_ready, tx_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({tx_out, tx_frame, in_ready} !== 3'b001) begin
                errs++;
                $display("FAIL mid_no_resume: out/frame/ready=%b want 001", {tx_out, tx_frame, in_ready});
            end
        end
        test_frame("after_rst", 8'hA5, 11'b11010010100);
    endtask

    task automatic test_sweep();
        logic [19:0] line, done;
        @(negedge clk);
        b_data = 1'b1;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        b_data = 1'b0;
        for (int i = 0; i < 20; i++) begin
            line[i] = b_out;
            done[i] = b_done;
            @(negedge clk);
        end
        checks++;
        if (line !== 20'h07FFF) begin errs++; $display("FAIL sweep_line: got %b want %b", line, 20'h07FFF); end
        checks++;
        if (done !== 20'h80000) begin errs++; $display("FAIL sweep_done: got %b want %b", done, 20'h80000); end
        checks++;
        if ({b_frame, b_ready} !== 2'b01) begin
            errs++;
            $display("FAIL sweep_idle_after: frame/ready=%b want 01", {b_frame, b_ready});
        end
    endtask

    initial begin
        test_reset();
        test_frame("a5", 8'hA5, 11'b11010010100);
        test_frame("00", 8'h00, 11'b10000000000);
        test_frame("ff", 8'hFF, 11'b11111111100);
        test_frame("01", 8'h01, 11'b11000000010);
        test_back_to_back();
        test_reset_mid_frame();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
